// File: rtl/ddf_pkg.sv
// ---------------------------------------------------------------------------
// ddf_pkg
// Shared definitions for the DDF control-token scheduler:
//   clog2      - ceiling log2 helper usable in constant expressions
//   MAX_PORTS  - largest supported number of steered data ports
//   NDA_IDX_W  - width of a port index (sized for MAX_PORTS)
//   sched_state_e - scheduler FSM encoding (IDLE / RUN)
// ---------------------------------------------------------------------------
package ddf_pkg;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int MAX_PORTS = 8;
  localparam int NDA_IDX_W = clog2(MAX_PORTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational arbiter over PORTS requesters.
//   req_i        - request vector (eligible ports)
//   last_grant_i - index granted most recently (round-robin pointer)
//   prio_mode_i  - 0: round-robin starting after last_grant_i
//                  1: fixed priority, lowest index wins
//   grant_o      - one-hot grant (all zero when no request)
//   grant_idx_o  - index of the granted port
//   grant_vld_o  - at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import ddf_pkg::*;
#(
  parameter int PORTS = 2
) (
  input  logic [PORTS-1:0]     req_i,
  input  logic [NDA_IDX_W-1:0] last_grant_i,
  input  logic                 prio_mode_i,
  output logic [PORTS-1:0]     grant_o,
  output logic [NDA_IDX_W-1:0] grant_idx_o,
  output logic                 grant_vld_o
);

  int cand;

  // Scan in reverse order of preference and overwrite, so the most
  // preferred requester is the one left standing at the end.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = |req_i;
    cand        = 0;
    if (prio_mode_i) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          grant_o     = '0;
          grant_o[i]  = 1'b1;
          grant_idx_o = NDA_IDX_W'(i);
        end
      end
    end else begin
      // Offset PORTS wraps back to last_grant itself: it is the least preferred.
      for (int off = PORTS; off >= 1; off--) begin
        cand = int'(last_grant_i) + off;
        if (cand >= PORTS) begin
          cand = cand - PORTS;
        end
        if (req_i[cand]) begin
          grant_o       = '0;
          grant_o[cand] = 1'b1;
          grant_idx_o   = NDA_IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/ddf_nda_scheduler.sv
// ---------------------------------------------------------------------------
// ddf_nda_scheduler
// Produces the control-token (nda) stream that steers a DDF actor to one of
// PORTS data inputs. Write strobes of the per-port data FIFOs are snooped to
// keep a pending-token count per port; whenever a port holds at least RATE
// tokens and the nda FIFO has room, one token carrying that port index is
// written.
// Ports:
//   ck        - clock
//   rst       - synchronous active-high reset
//   en        - scheduling enable (counting continues while low)
//   prio_mode - 0 round-robin, 1 fixed priority (lowest index wins)
//   flush     - one-cycle pulse: clear counts, abort pending grant
//   in_wr     - per-port data FIFO write strobes
//   nda_full  - nda FIFO full flag
//   nda_wr    - nda FIFO write strobe (registered)
//   nda_data  - granted port index, zero-extended (registered)
//   overflow  - sticky per-port counter overflow
//   busy      - some port currently holds >= RATE tokens
// ---------------------------------------------------------------------------
module ddf_nda_scheduler
  import ddf_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int WIDTH = 8,
  parameter int FLUX  = 2,
  parameter int DEPTH = 4,
  parameter int RATE  = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             prio_mode,
  input  logic             flush,
  input  logic [PORTS-1:0] in_wr,
  input  logic             nda_full,
  output logic             nda_wr,
  output logic [WIDTH-1:0] nda_data,
  output logic [PORTS-1:0] overflow,
  output logic             busy
);

  localparam int MAXCNT = DEPTH * FLUX;
  localparam int CW     = clog2(MAXCNT + 1);
  localparam logic [CW-1:0] RATE_C = CW'(RATE);
  localparam logic [CW-1:0] MAX_C  = CW'(MAXCNT);

  sched_state_e         state_q;
  logic [CW-1:0]        count_q [PORTS];
  logic [CW-1:0]        count_d [PORTS];
  logic [PORTS-1:0]     overflow_q, overflow_d;
  logic [NDA_IDX_W-1:0] last_grant_q;
  logic                 nda_wr_q;
  logic [WIDTH-1:0]     nda_data_q;

  logic [PORTS-1:0]     elig_s;
  logic [PORTS-1:0]     grant_oh_s;
  logic [NDA_IDX_W-1:0] grant_idx_s;
  logic                 grant_vld_s;
  logic                 do_grant_s;

  // Eligibility looks only at registered counts, so a strobe this cycle
  // cannot make its port grantable until the next cycle.
  always_comb begin
    elig_s = '0;
    for (int p = 0; p < PORTS; p++) begin
      elig_s[p] = (count_q[p] >= RATE_C);
    end
  end

  rr_arbiter #(
    .PORTS(PORTS)
  ) u_arb (
    .req_i       (elig_s),
    .last_grant_i(last_grant_q),
    .prio_mode_i (prio_mode),
    .grant_o     (grant_oh_s),
    .grant_idx_o (grant_idx_s),
    .grant_vld_o (grant_vld_s)
  );

  // en low blocks new grants immediately; flush aborts the decision.
  assign do_grant_s = (state_q == ST_RUN) && en && !nda_full && !flush && grant_vld_s;

  // Net count update: +1 per strobe, -RATE per grant. A strobe into a full
  // counter without a same-cycle grant is lost and flagged as overflow.
  always_comb begin
    overflow_d = overflow_q;
    for (int p = 0; p < PORTS; p++) begin
      count_d[p] = count_q[p];
      if (flush) begin
        count_d[p] = '0;
      end else if (in_wr[p] && (count_q[p] == MAX_C) && !(do_grant_s && grant_oh_s[p])) begin
        overflow_d[p] = 1'b1;
      end else begin
        count_d[p] = count_q[p] + CW'(in_wr[p])
                   - ((do_grant_s && grant_oh_s[p]) ? RATE_C : '0);
      end
    end
  end

  // FSM, counters, pointer and registered nda outputs.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      for (int p = 0; p < PORTS; p++) begin
        count_q[p] <= '0;
      end
      overflow_q   <= '0;
      last_grant_q <= NDA_IDX_W'(PORTS - 1);
      nda_wr_q     <= 1'b0;
      nda_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (en)  state_q <= ST_RUN;
        ST_RUN:  if (!en) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      count_q    <= count_d;
      overflow_q <= overflow_d;
      nda_wr_q   <= do_grant_s;
      if (do_grant_s) begin
        nda_data_q   <= WIDTH'(grant_idx_s);
        last_grant_q <= grant_idx_s;
      end
    end
  end

  assign nda_wr   = nda_wr_q;
  assign nda_data = nda_data_q;
  assign overflow = overflow_q;
  assign busy     = |elig_s;

endmodule

// File: doc/ddf_nda_scheduler.md
Name: ddf_nda_scheduler

Overview:
- Generates the control-token (nda) stream that steers a DDF actor to one of PORTS data inputs.
- Snoops the write strobes of the per-port data FIFOs and keeps a pending-token count per port.
- When a port holds at least RATE tokens and the nda FIFO has room, it issues one control token carrying that port index.
- Sits between the producers and the nda FIFO_MS of a DDF actor wrapper, replacing a hand-driven nda input.

Parameters:
- PORTS, 2, number of data input ports of the steered DDF actor (2..8).
- WIDTH, 8, nda data width; port index is zero-extended to WIDTH.
- FLUX, 2, slots per data FIFO.
- DEPTH, 4, depth per slot of each data FIFO.
- RATE, 1, tokens consumed from the selected port per firing (1..DEPTH*FLUX).

Ports:
- ck  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  scheduling enable; counting continues while low.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- flush  in  1  single-cycle pulse; clears all counts and aborts any pending grant.
- in_wr  in  PORTS  per-port write strobe snooped from the data FIFO inputs.
- nda_full  in  1  full flag of the nda FIFO.
- nda_wr  out  1  nda FIFO write strobe.
- nda_data  out  WIDTH  selected port index.
- overflow  out  PORTS  sticky per-port counter overflow flag.
- busy  out  1  high when any count is >= RATE.

Behaviour:
- One clock ck. Reset is synchronous and active-high on rst. All state changes on the rising edge of ck.
- Reset values:
  - nda_wr=0, nda_data=0, overflow=0, busy=0.
  - All counts=0.
  - Round-robin pointer last_grant = PORTS-1, so port 0 is first.
  - State = IDLE.
- Counters:
  - MAXCNT = DEPTH*FLUX; count width CW = $clog2(MAXCNT+1).
  - Each cycle, count[p] += in_wr[p], and count[p] -= RATE if p is granted that cycle. Both happen on the same edge (net effect).
  - Increment when count[p]==MAXCNT with no same-cycle grant: count holds and overflow[p] sets. overflow clears only on rst.
- Eligibility: elig[p] = (count[p] >= RATE), computed from registered counts only. An in_wr strobe cannot make a port eligible in the same cycle.
- State machine:
  - IDLE: enter RUN when en=1.
  - RUN: enter IDLE when en=0, which blocks new grants. A token already registered on nda_wr still completes.
- Grant, in RUN when nda_full=0 and any elig bit is set:
  - Round-robin: choose the first eligible port scanning last_grant+1 upward with wrap-around modulo PORTS.
  - Fixed priority: choose the lowest eligible index. last_grant still updates.
  - The grant decrements the count on that edge.
  - Next cycle: nda_wr=1 for exactly one cycle, nda_data = index.
- Latency: in_wr in cycle 0 gives count visible in cycle 1, grant at the end of cycle 1, nda_wr=1 in cycle 2 (RATE=1).
- Throughput: at most one token per cycle. Back-to-back grants are allowed while nda_full stays 0.
- nda_full handling:
  - nda_full=1 in the decision cycle means no grant. Counts and pointer are held, except increments.
  - nda_full rising in the same cycle that nda_wr is high is not this block's concern; the FIFO's full flag must already reflect occupancy one entry early.
- flush priority is over everything except rst:
  - counts=0, nda_wr=0 next cycle.
  - in_wr in the same cycle is discarded.
  - overflow and the pointer are unchanged.
- rst mid-operation returns every register to its reset value at the next edge. A registered nda_wr is dropped.
- busy = OR of the elig bits (combinational from registers).

Decomposition:
- Shared package ddf_pkg:
  - function clog2.
  - localparam-style constants NDA_IDX_W and the state encoding for IDLE and RUN.
- One sub-module rr_arbiter (PORTS wide: req, last_grant, prio_mode in; one-hot grant and index out), purely combinational.
- Counters, FSM and output register live in the top block.

Test Plan:
- Single token: PORTS=2, RATE=1. in_wr=2'b01 in cycle 0 -> nda_wr=1 with nda_data=0 in cycle 2 only. count[0] returns to 0.
- Round-robin fairness: both ports are loaded with 3 tokens, then en=1 with nda_full=0. nda_data sequence must be 0,1,0,1,0,1 on 6 consecutive cycles.
- Fixed priority: same load with prio_mode=1. Sequence must be 0,0,0,1,1,1.
- Backpressure: nda_full=1 for 5 cycles with count[1]=2. No nda_wr during that time. After release, two tokens with index 1 on consecutive cycles.
- RATE=2 and overflow: 3 strobes on port 0 give one token, and count[0]=1 remains. Then 9 strobes with nda_full=1 saturate the count at 8 and set overflow[0]=1.
- flush and rst: flush during a burst means nda_wr=0 next cycle and counts=0, with overflow retained. rst mid-burst clears overflow, and the first grant afterwards goes to port 0.
